stream_reorder: RTL and testbench
=================================

STREAM_REORDER -- requirements
Module: stream_reorder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, legal range 2..256.
REQ-002 SHALL have parameter MAX_SLICE, default 8: largest legal slice size, legal range 1..WIDTH.
REQ-003 SHALL have parameter SLICE_W, default $clog2(MAX_SLICE+1): width of the slice-size field.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  source word present.
REQ-007 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  source word.
REQ-009 SHALL have port in_dir  input  1  1 = left-stream (<<), 0 = right-stream (>>).
REQ-010 SHALL have port in_slice  input  SLICE_W  slice size in bits.
REQ-011 SHALL have port out_valid  output  1  result word present.
REQ-012 SHALL have port out_ready  input  1  sink accepts the result.
REQ-013 SHALL have port out_data  output  WIDTH  streamed result.
REQ-014 SHALL have port out_err  output  1  result came from an illegal slice size.
REQ-015 SHALL have port out_count  output  16  number of results accepted by the sink.

Function
REQ-016 SHALL treat an input transfer as in_valid && in_ready on a rising edge, and an output transfer as out_valid && out_ready on a rising edge.
REQ-017 SHALL capture in_data, in_dir and in_slice together on each input transfer; these fields SHALL be ignored on any other cycle.
REQ-018 SHALL be a two-stage pipeline: stage S1 registers the captured fields, stage S2 registers the computed result; latency is 2 cycles from input transfer to out_valid with no backpressure.
REQ-019 SHALL advance each stage when that stage is empty or its content moves on in the same cycle.
REQ-020 SHALL drive in_ready = !rst && (!S1_valid || !S2_valid || out_ready), combinationally.
REQ-021 SHALL sustain one transfer per cycle when out_ready is held high.
REQ-022 SHALL hold out_data, out_err and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL define legal slice size s as 1 <= in_slice <= MAX_SLICE.
REQ-024 With in_dir=1 and legal s, SHALL compute out_data as follows:
- Cut in_data into blocks from the LSB end: block k = bits [min(k*s+s-1, WIDTH-1) : k*s].
- Place block 0 at the MSB end of out_data, then block 1 directly below it, and so on.
- The last block may be shorter than s.
REQ-025 With in_dir=1 and s >= WIDTH, SHALL output out_data = in_data unchanged.
REQ-026 With in_dir=0 and legal s, SHALL output out_data = in_data unchanged.
REQ-027 With an illegal slice size (0 or > MAX_SLICE), SHALL output out_data = in_data and out_err=1, for either direction.
REQ-028 With a legal slice size, SHALL output out_err=0.
REQ-029 SHALL compute the reorder for every s in 1..MAX_SLICE; the fabric is not restricted to power-of-two slice sizes.
REQ-030 SHALL increment out_count by 1 on each output transfer, wrapping from 0xFFFF to 0x0000.
REQ-031 On simultaneous input and output transfers with both stages full, SHALL move the S1 word into S2 and load the new input into S1 in the same cycle, with no loss or duplication.

Reset
REQ-032 While rst=1, SHALL force S1_valid=0, S2_valid=0, out_valid=0, out_data=0, out_err=0, out_count=0 and in_ready=0, independent of clk.
REQ-033 SHALL discard any in-flight words when rst asserts mid-operation; the first out_valid after reset SHALL carry a word accepted after reset release.
REQ-034 SHALL drive in_ready=1 in the first cycle after reset release.

Verification
REQ-035 Bench SHALL cover, at WIDTH=4, in_data=4'b0001, in_dir=1:
- s=1 -> 4'b1000
- s=2 -> 4'b0100
- s=3 -> 4'b0010
- s=4 -> 4'b0001
- with MAX_SLICE=4, s=5 -> 4'b0001 and out_err=1
REQ-036 Bench SHALL cover, at WIDTH=32, in_dir=1:
- in_data=0x04030201, s=1 -> 0x8040C020
- in_data=0x04030201, s=8 -> 0x01020304
- in_data=0x00000001, s=3 -> 0x20000000
- in_data=0x00000001, s=5 -> 0x08000000
REQ-037 Bench SHALL cover in_dir=0, in_data=0x04030201, s=5 -> 0x04030201 with out_err=0; and s=0 with either direction -> 0x04030201 with out_err=1.
REQ-038 Bench SHALL cover backpressure: 8 back-to-back words with out_ready held low for 5 cycles, then high:
- in_ready falls after 2 words are accepted.
- All 8 results emerge in order with no loss.
- out_data is held stable while stalled.
- out_count ends at 8.
REQ-039 Bench SHALL cover counter wrap: preload via 65536 output transfers -> out_count=0x0000, then one more transfer -> 0x0001.
REQ-040 Bench SHALL cover reset mid-stream: assert rst with both stages full -> out_valid=0 and out_count=0 immediately; after release, the first output is the first post-reset input.

Source files
------------

// File: rtl/stream_reorder.sv
// stream_reorder: two-stage valid/ready pipeline that applies a left-stream
// (<<) slice reorder to each word. Right-stream words and words with an
// illegal slice size pass through unchanged; an illegal slice size is flagged
// on out_err.
module stream_reorder #(
    parameter int WIDTH     = 32,
    parameter int MAX_SLICE = 8,
    parameter int SLICE_W   = $clog2(MAX_SLICE + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_dir,
    input  logic [SLICE_W-1:0] in_slice,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_err,
    output logic [15:0]        out_count
);

    // Stage 1 registers (captured input fields)
    logic               r_vld_p1;
    logic [WIDTH-1:0]   r_data_p1;
    logic               r_dir_p1;
    logic [SLICE_W-1:0] r_slice_p1;

    // Stage 2 registers (computed result)
    logic               r_vld_p2;
    logic [WIDTH-1:0]   r_data_p2;
    logic               r_err_p2;
    logic [15:0]        r_count;

    logic w_adv_p1;
    logic w_adv_p2;
    logic w_in_fire;
    logic w_out_fire;

    // Each candidate slice size gets a fixed bit permutation; the live slice
    // size selects one of them, so any size 1..MAX_SLICE is supported.
    logic [MAX_SLICE-1:0][WIDTH-1:0] w_perm;
    logic [MAX_SLICE-1:0]            w_hit;
    logic [WIDTH-1:0]                w_reord;
    logic                            w_legal;
    logic [WIDTH-1:0]                w_res;
    logic                            w_err;

    // A stage may load when it is empty or its occupant leaves this cycle.
    assign w_adv_p2   = !r_vld_p2 || out_ready;
    assign w_adv_p1   = !r_vld_p1 || w_adv_p2;
    assign in_ready   = !rst && w_adv_p1;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_vld_p2 && out_ready;

    assign out_valid = r_vld_p2;
    assign out_data  = r_data_p2;
    assign out_err   = r_err_p2;
    assign out_count = r_count;

    // Block k (bits k*s upward) lands directly below block k-1, starting at
    // the MSB. Full blocks occupy [W-(k+1)*s +: s]; the short tail block, if
    // any, fills the bottom bits. Sizes >= WIDTH reduce to the identity.
    for (genvar gs = 1; gs <= MAX_SLICE; gs++) begin : g_slice
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            localparam int K   = gi / gs;
            localparam int O   = gi % gs;
            localparam int DST = ((K + 1) * gs <= WIDTH) ? (WIDTH - (K + 1) * gs + O) : O;
            assign w_perm[gs-1][DST] = r_data_p1[gi];
        end
        assign w_hit[gs-1] = (r_slice_p1 == SLICE_W'(gs));
    end

    assign w_legal = (r_slice_p1 != '0) && (r_slice_p1 <= SLICE_W'(MAX_SLICE));

    // One-hot select of the permutation matching the captured slice size.
    always_comb begin
        w_reord = '0;
        for (int s = 0; s < MAX_SLICE; s++) begin
            w_reord = w_reord | (w_perm[s] & {WIDTH{w_hit[s]}});
        end
    end

    // Choose between reordered and pass-through data, and flag illegal sizes.
    always_comb begin
        w_res = r_data_p1;
        w_err = !w_legal;
        if (w_legal && r_dir_p1) begin
            w_res = w_reord;
        end
    end

    // Stage 1 data capture; only meaningful while r_vld_p1 is set.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_data_p1  <= in_data;
            r_dir_p1   <= in_dir;
            r_slice_p1 <= in_slice;
        end
    end

    // Pipeline control, stage 2 result and output transfer counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_err_p2  <= 1'b0;
            r_count   <= 16'd0;
        end else begin
            if (w_adv_p1) begin
                r_vld_p1 <= in_valid;
            end
            if (w_adv_p2) begin
                r_vld_p2 <= r_vld_p1;
                if (r_vld_p1) begin
                    r_data_p2 <= w_res;
                    r_err_p2  <= w_err;
                end
            end
            if (w_out_fire) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_stream_reorder.sv
// Directed testbench for stream_reorder: a 4-bit instance (MAX_SLICE=4) and a
// 32-bit instance (MAX_SLICE=8) share one clock.
module tb_stream_reorder;

    logic clk;

    // 4-bit instance
    logic        a_rst, a_in_valid, a_in_ready, a_in_dir;
    logic [3:0]  a_in_data, a_out_data;
    logic [2:0]  a_in_slice;
    logic        a_out_valid, a_out_ready, a_out_err;
    logic [15:0] a_out_count;

    // 32-bit instance
    logic        b_rst, b_in_valid, b_in_ready, b_in_dir;
    logic [31:0] b_in_data, b_out_data;
    logic [3:0]  b_in_slice;
    logic        b_out_valid, b_out_ready, b_out_err;
    logic [15:0] b_out_count;

    stream_reorder #(.WIDTH(4), .MAX_SLICE(4)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_dir(a_in_dir), .in_slice(a_in_slice),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_err(a_out_err), .out_count(a_out_count)
    );

    stream_reorder #(.WIDTH(32), .MAX_SLICE(8)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_dir(b_in_dir), .in_slice(b_in_slice),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_err(b_out_err), .out_count(b_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Send one word into an empty pipeline and wait (bounded) for its result.
    task automatic xfer(input bit sel, input logic [31:0] d, input logic dir,
                        input logic [3:0] sl, output logic [31:0] od,
                        output logic oe, output bit ok);
        ok = 1'b0;
        od = '0;
        oe = 1'b0;
        @(negedge clk);
        if (sel) begin
            b_in_valid = 1'b1; b_in_data = d; b_in_dir = dir; b_in_slice = sl; b_out_ready = 1'b1;
        end else begin
            a_in_valid = 1'b1; a_in_data = d[3:0]; a_in_dir = dir; a_in_slice = sl[2:0]; a_out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (sel ? b_out_valid : a_out_valid) begin
                od = sel ? b_out_data : {28'd0, a_out_data};
                oe = sel ? b_out_err : a_out_err;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        bit          sel;
        logic [31:0] d;
        logic        dir;
        logic [3:0]  sl;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t        tbl [18];
    logic [31:0] words [8];
    logic [31:0] od;
    logic        oe;
    bit          ok;
    int          idx, oidx, blk_at, n;
    bit          acc;

    initial begin
        tbl[0]  = '{1'b0, 32'h1,        1'b1, 4'd1, 32'h8,        1'b0};
        tbl[1]  = '{1'b0, 32'h1,        1'b1, 4'd2, 32'h4,        1'b0};
        tbl[2]  = '{1'b0, 32'h1,        1'b1, 4'd3, 32'h2,        1'b0};
        tbl[3]  = '{1'b0, 32'h1,        1'b1, 4'd4, 32'h1,        1'b0};
        tbl[4]  = '{1'b0, 32'h1,        1'b1, 4'd5, 32'h1,        1'b1};
        tbl[5]  = '{1'b0, 32'h1,        1'b1, 4'd0, 32'h1,        1'b1};
        tbl[6]  = '{1'b1, 32'h04030201, 1'b1, 4'd1, 32'h8040C020, 1'b0};
        tbl[7]  = '{1'b1, 32'h04030201, 1'b1, 4'd8, 32'h01020304, 1'b0};
        tbl[8]  = '{1'b1, 32'h00000001, 1'b1, 4'd3, 32'h20000000, 1'b0};
        tbl[9]  = '{1'b1, 32'h00000001, 1'b1, 4'd5, 32'h08000000, 1'b0};
        tbl[10] = '{1'b1, 32'h04030201, 1'b0, 4'd5, 32'h04030201, 1'b0};
        tbl[11] = '{1'b1, 32'h04030201, 1'b0, 4'd0, 32'h04030201, 1'b1};
        tbl[12] = '{1'b1, 32'h04030201, 1'b1, 4'd0, 32'h04030201, 1'b1};
        tbl[13] = '{1'b1, 32'h04030201, 1'b1, 4'd9, 32'h04030201, 1'b1};
        tbl[14] = '{1'b1, 32'h12345678, 1'b1, 4'd4, 32'h87654321, 1'b0};
        tbl[15] = '{1'b1, 32'h80000000, 1'b1, 4'd3, 32'h00000002, 1'b0};
        tbl[16] = '{1'b1, 32'h00000001, 1'b1, 4'd7, 32'h02000000, 1'b0};
        tbl[17] = '{1'b1, 32'h0000003F, 1'b1, 4'd6, 32'hFC000000, 1'b0};
        for (int i = 0; i < 8; i++) words[i] = 32'h0A0B0C00 | i;

        a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_in_dir = 1'b0; a_in_slice = '0; a_out_ready = 1'b0;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_in_dir = 1'b0; b_in_slice = '0; b_out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_a_out_valid", a_out_valid, 0);
        chk("rst_a_out_data",  a_out_data, 0);
        chk("rst_a_in_ready",  a_in_ready, 0);
        chk("rst_a_out_count", a_out_count, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_out_data",  b_out_data, 0);
        chk("rst_b_out_err",   b_out_err, 0);
        chk("rst_b_out_count", b_out_count, 0);
        chk("rst_b_in_ready",  b_in_ready, 0);
        @(negedge clk);
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;
        chk("post_rst_in_ready", b_in_ready, 1);

        // Vector table
        for (int i = 0; i < 18; i++) begin
            xfer(tbl[i].sel, tbl[i].d, tbl[i].dir, tbl[i].sl, od, oe, ok);
            chk($sformatf("vec%0d_timeout", i), ok, 1);
            chk($sformatf("vec%0d_data", i), od, tbl[i].exp);
            chk($sformatf("vec%0d_err", i), oe, tbl[i].err);
        end

        // Backpressure: 8 words, out_ready low for 5 cycles
        @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        idx = 0; oidx = 0; blk_at = -1;
        for (int c = 0; c < 40 && oidx < 8; c++) begin
            @(negedge clk);
            b_out_ready = (c >= 5);
            if (idx < 8) begin
                b_in_valid = 1'b1; b_in_data = words[idx]; b_in_dir = 1'b1; b_in_slice = 4'd8;
            end else begin
                b_in_valid = 1'b0;
            end
            #1;
            if (idx < 8 && !b_in_ready && blk_at < 0) blk_at = idx;
            if (b_out_valid) begin
                if (b_out_ready) begin
                    chk($sformatf("bp_out%0d", oidx), b_out_data, bswap(words[oidx]));
                    oidx++;
                end else begin
                    chk($sformatf("bp_stall_c%0d", c), b_out_data, bswap(words[oidx]));
                end
            end
            acc = b_in_valid && b_in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        b_out_ready = 1'b0;
        #1;
        chk("bp_ready_fall_after", blk_at, 2);
        chk("bp_all_out", oidx, 8);
        chk("bp_count", b_out_count, 8);

        // Reset with both stages full
        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = 32'hAAAA0001; b_in_dir = 1'b0; b_in_slice = 4'd8;
        @(posedge clk);
        @(negedge clk);
        b_in_data = 32'hAAAA0002;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        #1;
        chk("mid_pre_full_in_ready", b_in_ready, 0);
        b_rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", b_out_valid, 0);
        chk("mid_rst_out_count", b_out_count, 0);
        chk("mid_rst_in_ready", b_in_ready, 0);
        @(negedge clk);
        b_rst = 1'b0;
        #1;
        chk("mid_rel_in_ready", b_in_ready, 1);
        xfer(1'b1, 32'h55550003, 1'b0, 4'd8, od, oe, ok);
        chk("mid_first_timeout", ok, 1);
        chk("mid_first_data", od, 32'h55550003);

        // Counter wrap: 65536 transfers then one more
        @(negedge clk);
        b_rst = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        b_in_valid = 1'b1; b_in_data = 32'h00000123; b_in_dir = 1'b0; b_in_slice = 4'd1;
        b_out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 70000 && n < 65536; c++) begin
            @(negedge clk);
            #1;
            if (b_out_valid) n++;
            @(posedge clk);
        end
        @(negedge clk);
        b_out_ready = 1'b0;
        b_in_valid = 1'b0;
        #1;
        chk("wrap_transfers", n, 65536);
        chk("wrap_count_zero", b_out_count, 0);
        chk("wrap_pending_valid", b_out_valid, 1);
        b_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_out_ready = 1'b0;
        #1;
        chk("wrap_count_one", b_out_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
